cpu_seq_ctrl: RTL and testbench

- Fetch/execute sequencer for the 16x8 program ROM (4-bit address in, 8-bit word out, combinational read).
- Owns the program counter, instruction register, accumulator, flags and output register.
- Multiplexes the single ROM address port between instruction fetch (PC) and operand fetch (IR operand field).
- Sits between the ROM and the output/display logic as the CPU control core.

---
 rtl/cpu_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: fetch/execute sequencer for a 16x8 program ROM.
// Owns the program counter, instruction register, accumulator, Z/C flags
// and the output register. The single ROM address port is shared between
// instruction fetch (PC) and operand fetch (IR operand field, MEM state).
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   run        level enable, only looked at in FETCH
//   rom_addr   ROM address (operand field in MEM, PC otherwise)
//   rom_data   ROM read data, valid in the same cycle as rom_addr
//   out_port   output register, loaded by OUT
//   out_valid  single-cycle pulse in the cycle after OUT executes
//   zero_flag  Z flag
//   carry_flag C flag (ADD carry-out / SUB borrow)
//   halted     high while in HALT
//   pc_dbg     current program counter
module cpu_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int OP_W = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                z_q, z_d;
  logic                c_q, c_d;

  logic [OP_W-1:0]     opcode;
  logic [ADDR_W-1:0]   operand;
  // One extra bit holds the ADD carry-out; for SUB it is set exactly when
  // the subtrahend exceeds the accumulator, i.e. the borrow.
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  assign opcode  = ir_q[DATA_W-1:ADDR_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, rom_data};
  assign diff    = {1'b0, acc_q} - {1'b0, rom_data};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (run) state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: state_d = S_MEM;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM:   state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    rom_addr = (state_q == S_MEM) ? operand : pc_q;
    halted   = (state_q == S_HALT);
  end

  // Datapath next-state
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    z_d         = z_q;
    c_d         = c_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d = rom_data;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LDI: begin
            acc_d = {{OP_W{1'b0}}, operand};
            z_d   = (operand == '0);
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_OUT: begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        case (opcode)
          OP_LDA: begin
            acc_d = rom_data;
            z_d   = (rom_data == '0);
          end
          OP_ADD: begin
            acc_d = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
            z_d   = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            acc_d = diff[DATA_W-1:0];
            c_d   = diff[DATA_W];
            z_d   = (diff[DATA_W-1:0] == '0);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  assign out_port   = out_q;
  assign out_valid  = out_valid_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign pc_dbg     = pc_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl. The bench owns a 16x8 program ROM
// and each task loads a small program, runs it cycle by cycle and compares
// the visible outputs against hand-derived values. Outputs are sampled 1ns
// after the rising edge; "step n" means n rising edges after rst released.
module tb_cpu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_port;
  logic       out_valid;
  logic       zero_flag;
  logic       carry_flag;
  logic       halted;
  logic [3:0] pc_dbg;

  logic [7:0] rom [16];

  int checks = 0;
  int errors = 0;

  assign rom_data = rom[rom_addr];

  cpu_seq_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .halted     (halted),
    .pc_dbg     (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // LDA 14 ; ADD 15 ; OUT ; HLT with ROM[14]=5, ROM[15]=3 -> prints 8
  task automatic load_prog_out8();
    clear_rom();
    rom[0] = 8'h1E; rom[1] = 8'h2F; rom[2] = 8'hE0; rom[3] = 8'hF0;
    rom[14] = 8'h05; rom[15] = 8'h03;
  endtask

  task automatic test_reset();
    load_prog_out8();
    run = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (rom_addr !== 4'h0) begin errors++; $display("FAIL reset_rom_addr got %0h exp 0", rom_addr); end
    checks++; if (pc_dbg !== 4'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc_dbg); end
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_port got %0h exp 0", out_port); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_z got %0b exp 0", zero_flag); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL reset_c got %0b exp 0", carry_flag); end
    rst = 1'b0;
    step();
    // First fetch from address 0 advanced PC to 1
    checks++; if (pc_dbg !== 4'h1) begin errors++; $display("FAIL reset_first_fetch pc got %0h exp 1", pc_dbg); end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_out_halt();
    load_prog_out8();
    run = 1'b1;
    apply_reset();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      checks++; if (out_valid !== (cyc == 8)) begin errors++; $display("FAIL out_halt_valid step %0d got %0b exp %0b", cyc, out_valid, (cyc == 8)); end
      checks++; if (halted !== (cyc >= 10)) begin errors++; $display("FAIL out_halt_halted step %0d got %0b exp %0b", cyc, halted, (cyc >= 10)); end
    end
    checks++; if (out_port !== 8'h08) begin errors++; $display("FAIL out_halt_port got %0h exp 08", out_port); end
    checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL out_halt_z got %0b exp 0", zero_flag); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL out_halt_c got %0b exp 0", carry_flag); end
    checks++; if (pc_dbg !== 4'h4) begin errors++; $display("FAIL out_halt_pc got %0h exp 4", pc_dbg); end
    run = 1'b0; step();
    run = 1'b1; step(); step();
    checks++; if (halted !== 1'b1 || pc_dbg !== 4'h4 || rom_addr !== 4'h4) begin
      errors++; $display("FAIL out_halt_frozen halted %0b pc %0h addr %0h exp 1 4 4", halted, pc_dbg, rom_addr);
    end
    $display("test_out_halt done checks=%0d errors=%0d", checks, errors);
  endtask

  // LDI 2 ; SUB 15 (ROM[15]=5) ; JC 5 ; ... [5] OUT ; [6] HLT
  task automatic test_sub_jc();
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'h3F; rom[2] = 8'h75; rom[3] = 8'hF0;
    rom[5] = 8'hE0; rom[6] = 8'hF0; rom[15] = 8'h05;
    run = 1'b1;
    apply_reset();
    for (int cyc = 1; cyc <= 11; cyc++) begin
      step();
      if (cyc == 5) begin
        checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL sub_borrow c got %0b exp 1", carry_flag); end
        checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL sub_z got %0b exp 0", zero_flag); end
      end
      if (cyc == 7) begin
        checks++; if (pc_dbg !== 4'h5) begin errors++; $display("FAIL jc_taken pc got %0h exp 5", pc_dbg); end
      end
      checks++; if (out_valid !== (cyc == 9)) begin errors++; $display("FAIL sub_jc_valid step %0d got %0b exp %0b", cyc, out_valid, (cyc == 9)); end
    end
    checks++; if (out_port !== 8'hFD) begin errors++; $display("FAIL sub_result got %0h exp fd", out_port); end
    checks++; if (halted !== 1'b1 || pc_dbg !== 4'h7) begin errors++; $display("FAIL sub_jc_halt halted %0b pc %0h exp 1 7", halted, pc_dbg); end
    $display("test_sub_jc done checks=%0d errors=%0d", checks, errors);
  endtask

  // LDA 14 (0xFF) ; ADD 15 (0x01) ; OUT ; HLT -> ACC=0, C=1, Z=1
  task automatic test_carry();
    clear_rom();
    rom[0] = 8'h1E; rom[1] = 8'h2F; rom[2] = 8'hE0; rom[3] = 8'hF0;
    rom[14] = 8'hFF; rom[15] = 8'h01;
    run = 1'b1;
    apply_reset();
    step(); step();
    checks++; if (rom_addr !== 4'hE) begin errors++; $display("FAIL carry_mem_addr got %0h exp e", rom_addr); end
    step();
    checks++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL carry_after_lda z %0b c %0b exp 0 0", zero_flag, carry_flag); end
    step(); step(); step();
    checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL carry_z got %0b exp 1", zero_flag); end
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL carry_c got %0b exp 1", carry_flag); end
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_port !== 8'h00) begin errors++; $display("FAIL carry_out valid %0b port %0h exp 1 00", out_valid, out_port); end
    step(); step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL carry_halt got %0b exp 1", halted); end
    $display("test_carry done checks=%0d errors=%0d", checks, errors);
  endtask

  // JZ/JC not taken with flags clear, then JZ taken after LDI 0
  task automatic test_jumps();
    clear_rom();
    rom[0] = 8'h41; rom[1] = 8'h65; rom[2] = 8'h75; rom[3] = 8'h40;
    rom[4] = 8'h69; rom[9] = 8'hE0; rom[10] = 8'hF0;
    run = 1'b1;
    apply_reset();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      if (cyc == 4) begin
        checks++; if (pc_dbg !== 4'h2) begin errors++; $display("FAIL jz_not_taken pc got %0h exp 2", pc_dbg); end
      end
      if (cyc == 6) begin
        checks++; if (pc_dbg !== 4'h3) begin errors++; $display("FAIL jc_not_taken pc got %0h exp 3", pc_dbg); end
      end
      if (cyc == 8) begin
        checks++; if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin errors++; $display("FAIL ldi0_flags z %0b c %0b exp 1 0", zero_flag, carry_flag); end
      end
      if (cyc == 10) begin
        checks++; if (pc_dbg !== 4'h9) begin errors++; $display("FAIL jz_taken pc got %0h exp 9", pc_dbg); end
      end
      checks++; if (out_valid !== (cyc == 12)) begin errors++; $display("FAIL jumps_valid step %0d got %0b exp %0b", cyc, out_valid, (cyc == 12)); end
    end
    checks++; if (halted !== 1'b1 || pc_dbg !== 4'hB) begin errors++; $display("FAIL jumps_halt halted %0b pc %0h exp 1 b", halted, pc_dbg); end
    $display("test_jumps done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [6];
    exp_pc = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h1, 4'hF};
    clear_rom();
    rom[0] = 8'h5F; rom[15] = 8'h00;
    run = 1'b1;
    apply_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      checks++; if (pc_dbg !== exp_pc[cyc]) begin errors++; $display("FAIL wrap_pc step %0d got %0h exp %0h", cyc + 1, pc_dbg, exp_pc[cyc]); end
    end
    $display("test_wrap done checks=%0d errors=%0d", checks, errors);
  endtask

  // LDI 3 ; 0x95 (undefined) ; OUT ; HLT
  task automatic test_undef();
    clear_rom();
    rom[0] = 8'h43; rom[1] = 8'h95; rom[2] = 8'hE0; rom[3] = 8'hF0;
    run = 1'b1;
    apply_reset();
    step(); step(); step(); step();
    checks++; if (pc_dbg !== 4'h2 || rom_addr !== 4'h2) begin errors++; $display("FAIL undef_pc pc %0h addr %0h exp 2 2", pc_dbg, rom_addr); end
    checks++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL undef_flags z %0b c %0b exp 0 0", zero_flag, carry_flag); end
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_port !== 8'h03) begin errors++; $display("FAIL undef_out valid %0b port %0h exp 1 03", out_valid, out_port); end
    step(); step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL undef_halt got %0b exp 1", halted); end
    $display("test_undef done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_run_hold();
    load_prog_out8();
    run = 1'b0;
    apply_reset();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      checks++; if (pc_dbg !== 4'h0 || rom_addr !== 4'h0 || out_valid !== 1'b0 || halted !== 1'b0) begin
        errors++; $display("FAIL run_hold step %0d pc %0h addr %0h valid %0b halted %0b exp 0 0 0 0", cyc, pc_dbg, rom_addr, out_valid, halted);
      end
    end
    run = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      checks++; if (out_valid !== (cyc == 8)) begin errors++; $display("FAIL run_resume_valid step %0d got %0b exp %0b", cyc, out_valid, (cyc == 8)); end
      checks++; if (halted !== (cyc >= 10)) begin errors++; $display("FAIL run_resume_halted step %0d got %0b exp %0b", cyc, halted, (cyc >= 10)); end
    end
    checks++; if (out_port !== 8'h08) begin errors++; $display("FAIL run_resume_port got %0h exp 08", out_port); end
    $display("test_run_hold done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_midway();
    load_prog_out8();
    run = 1'b1;
    apply_reset();
    step(); step(); step(); step(); step();
    // Now in MEM of ADD: operand address on the ROM port
    checks++; if (rom_addr !== 4'hF) begin errors++; $display("FAIL mid_mem_addr got %0h exp f", rom_addr); end
    rst = 1'b1;
    step();
    checks++; if (pc_dbg !== 4'h0 || rom_addr !== 4'h0 || halted !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_mem_reset pc %0h addr %0h halted %0b valid %0b exp 0 0 0 0", pc_dbg, rom_addr, halted, out_valid);
    end
    checks++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL mid_mem_reset_flags z %0b c %0b exp 0 0", zero_flag, carry_flag); end
    rst = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) step();
    checks++; if (out_port !== 8'h08 || halted !== 1'b1) begin errors++; $display("FAIL mid_mem_rerun port %0h halted %0b exp 08 1", out_port, halted); end

    // Reset from HALT with C=1 and out_port=0xFD
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'h3F; rom[2] = 8'h75; rom[3] = 8'hF0;
    rom[5] = 8'hE0; rom[6] = 8'hF0; rom[15] = 8'h05;
    apply_reset();
    for (int cyc = 1; cyc <= 12; cyc++) step();
    checks++; if (halted !== 1'b1 || carry_flag !== 1'b1 || out_port !== 8'hFD) begin
      errors++; $display("FAIL halt_precond halted %0b c %0b port %0h exp 1 1 fd", halted, carry_flag, out_port);
    end
    rst = 1'b1;
    step();
    checks++; if (halted !== 1'b0 || pc_dbg !== 4'h0 || out_port !== 8'h00) begin
      errors++; $display("FAIL halt_reset halted %0b pc %0h port %0h exp 0 0 00", halted, pc_dbg, out_port);
    end
    checks++; if (carry_flag !== 1'b0 || zero_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_reset_flags c %0b z %0b valid %0b exp 0 0 0", carry_flag, zero_flag, out_valid);
    end
    rst = 1'b0;
    $display("test_reset_midway done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    clear_rom();
    test_reset();
    test_out_halt();
    test_sub_jc();
    test_carry();
    test_jumps();
    test_wrap();
    test_undef();
    test_run_hold();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
